// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } pipe_state_e;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 16;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Control-bundle layout, kept in sync with the decoder.
  localparam int unsigned CTRL_REGWR_BIT  = 0;
  localparam int unsigned CTRL_MEMWR_BIT  = 1;
  localparam int unsigned CTRL_MEMRD_BIT  = 2;
  localparam int unsigned CTRL_BRANCH_BIT = 3;
  localparam int unsigned CTRL_ALU_LSB    = 4;
  localparam int unsigned CTRL_ALU_W      = 4;
  localparam int unsigned CTRL_WBSEL_BIT  = 15;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used by the pipeline-register perf hooks (PIPE_PERF_EN).
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready inter-stage register with 2-entry skid buffer and flush-to-bubble.
// Optional perf counters are built when PIPE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       PC_W     = PC_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  pipe_state_e       state;
  logic              valid_q, ready_q;
  logic [PC_W-1:0]   main_pc,   skid_pc;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  // Outputs come straight from flops: no combinational in_* -> out_* path.
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      main_pc   <= RESET_PC;
      main_data <= '0;
      main_ctrl <= '0;
      skid_pc   <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Kill everything held; pc/data stay as stale payload behind a NOP.
      state     <= EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_pc   <= in_pc;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            valid_q   <= 1'b1;
            state     <= FULL1;
          end
        end
        FULL1: begin
          if (in_fire && out_fire) begin
            main_pc   <= in_pc;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (in_fire) begin
            skid_pc   <= in_pc;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            ready_q   <= 1'b0;
            state     <= FULL2;
          end else if (out_fire) begin
            main_ctrl <= '0;
            valid_q   <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL2: begin
          if (out_ready) begin
            main_pc   <= skid_pc;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
            ready_q   <= 1'b1;
            state     <= FULL1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(valid_q & ~out_ready), .cnt(stall_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset(reset), .inc(~valid_q), .cnt(bubble_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .cnt(flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid stall, flush, drain, async reset.
module tb_pipe_stage_reg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  pipe_stage_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_data  = pc ^ 32'hA5A5_0000;
    in_ctrl  = ctrl;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_pc",    out_pc,             RST_PC);
    chk("rst_out_ctrl",  {16'd0, out_ctrl},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    #2 reset = 1'b0;

    // Streaming at full rate, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h4, 16'h0001); tick();
    chk("str_pc4",     out_pc, 32'h4);
    chk("str_valid",   {31'd0, out_valid}, 32'd1);
    chk("str_data4",   out_data, 32'hA5A5_0004);
    drive(1'b1, 32'h8, 16'h0002); tick();
    chk("str_pc8",     out_pc, 32'h8);
    chk("str_ready8",  {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'hC, 16'h0003); tick();
    chk("str_pcC",     out_pc, 32'hC);
    chk("str_ctrlC",   {16'd0, out_ctrl}, 32'h3);
    drive(1'b0, 32'h0, 16'h0); tick();
    chk("str_drain_v", {31'd0, out_valid}, 32'd0);
    chk("str_drain_c", {16'd0, out_ctrl}, 32'd0);
    chk("str_pc_hold", out_pc, 32'hC);

    // Stall into the skid buffer, then release in FIFO order
    out_ready = 1'b0;
    drive(1'b1, 32'h4, 16'h0011); tick();
    chk("stl_pc4",     out_pc, 32'h4);
    chk("stl_rdy1",    {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h8, 16'h0012); tick();
    chk("stl_hold4",   out_pc, 32'h4);
    chk("stl_full2",   {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC, 16'h0013); tick();
    chk("stl_still4",  out_pc, 32'h4);
    chk("stl_rdy0",    {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("rel_pc8",     out_pc, 32'h8);
    chk("rel_ctrl8",   {16'd0, out_ctrl}, 32'h12);
    chk("rel_rdy",     {31'd0, in_ready}, 32'd1);
    tick();
    chk("rel_pcC",     out_pc, 32'hC);
    chk("rel_ctrlC",   {16'd0, out_ctrl}, 32'h13);
    drive(1'b0, 32'h0, 16'h0); tick();
    chk("rel_empty",   {31'd0, out_valid}, 32'd0);

    // Flush while FULL2 with a live input that must be discarded
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 16'h0021); tick();
    drive(1'b1, 32'h24, 16'h0022); tick();
    chk("fl_full2",    {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h10, 16'h0031); tick();
    chk("fl_valid",    {31'd0, out_valid}, 32'd0);
    chk("fl_ctrl",     {16'd0, out_ctrl}, 32'd0);
    chk("fl_ready",    {31'd0, in_ready}, 32'd1);
    chk("fl_pc_hold",  out_pc, 32'h20);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 16'h0); tick();
    chk("fl_no_10_v",  {31'd0, out_valid}, 32'd0);
    chk("fl_no_10_pc", out_pc, 32'h20);

    // Bubble drain of a single entry
    drive(1'b1, 32'h40, 16'h8001); tick();
    chk("bub_valid",   {31'd0, out_valid}, 32'd1);
    chk("bub_ctrl",    {16'd0, out_ctrl}, 32'h8001);
    drive(1'b0, 32'h0, 16'h0); tick();
    chk("bub_gone_v",  {31'd0, out_valid}, 32'd0);
    chk("bub_gone_c",  {16'd0, out_ctrl}, 32'd0);

    // Async reset while FULL2
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 16'h0041); tick();
    drive(1'b1, 32'h54, 16'h0042); tick();
    chk("ar_full2",    {31'd0, in_ready}, 32'd0);
    reset = 1'b1; #1;
    chk("ar_valid",    {31'd0, out_valid}, 32'd0);
    chk("ar_ctrl",     {16'd0, out_ctrl}, 32'd0);
    chk("ar_pc",       out_pc, RST_PC);
    chk("ar_ready",    {31'd0, in_ready}, 32'd1);
    #2 reset = 1'b0;
    drive(1'b0, 32'h0, 16'h0); out_ready = 1'b1; tick();
    chk("ar_after_v",  {31'd0, out_valid}, 32'd0);
    chk("ar_after_pc", out_pc, RST_PC);

`ifdef PIPE_PERF_EN
    // Counters: one bubble cycle, 20 stall cycles (saturating), 3 flush cycles
    reset = 1'b1; #2;
    chk("pc_rst_stall",  {28'd0, stall_cnt},  32'd0);
    chk("pc_rst_bubble", {28'd0, bubble_cnt}, 32'd0);
    chk("pc_rst_flush",  {28'd0, flush_cnt},  32'd0);
    reset = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h60, 16'h0051); tick();
    drive(1'b0, 32'h0, 16'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("pc_stall_sat",  {28'd0, stall_cnt},  32'd15);
    chk("pc_bubble1",    {28'd0, bubble_cnt}, 32'd1);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b0;
    chk("pc_flush3",     {28'd0, flush_cnt},  32'd3);
    chk("pc_bubble3",    {28'd0, bubble_cnt}, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
